// File: rtl/event_trig_resolver.sv
// event_trig_resolver
// Resolves an event-triggered frame slot. A clean reply from one of the two
// associated unconditional frames is accepted directly. Anything else that
// is well framed is treated as a collision, and both unconditional frames
// are then polled in turn.
// Optional feature macro: EVT_TRIG_TIMEOUT_EN. When it is defined, a
// per-WAIT-state response timeout of TIMEOUT_CYC cycles is added and drives
// no_resp. Without the macro, WAIT states wait forever and no_resp is 0.
module event_trig_resolver #(
  parameter logic [5:0]  UNCOND_FRAME1 = 6'h25,
  parameter logic [5:0]  UNCOND_FRAME2 = 6'h26,
  parameter logic [15:0] TIMEOUT_CYC   = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_evenTrig_frame,
  input  logic       rx_valid,
  input  logic [9:0] data_published,
  output logic       collision_detected,
  output logic       frame_ok,
  output logic       rx_error,
  output logic       no_resp,
  output logic       resolve_req,
  output logic [5:0] resolve_pid,
  output logic [7:0] rx_pid,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_RESP = 3'd1;
  localparam logic [2:0] S_RES1      = 3'd2;
  localparam logic [2:0] S_WAIT1     = 3'd3;
  localparam logic [2:0] S_RES2      = 3'd4;
  localparam logic [2:0] S_WAIT2     = 3'd5;

  // Build the protected ID: {P1, P0, ID}.
  function automatic logic [7:0] f_pid(input logic [5:0] id);
    logic p0;
    logic p1;
    p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
    p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
    return {p1, p0, id};
  endfunction

  logic [2:0] r_state;
  logic       r_collision;
  logic       r_frame_ok;
  logic       r_rx_error;
  logic       r_resolve_req;
  logic [5:0] r_resolve_pid;
  logic [7:0] r_rx_pid;
  logic       r_busy;

  logic [2:0] w_nxt_state;
  logic       w_nxt_collision;
  logic       w_nxt_frame_ok;
  logic       w_nxt_rx_error;
  logic       w_nxt_no_resp;
  logic       w_nxt_resolve_req;
  logic [5:0] w_nxt_resolve_pid;
  logic [7:0] w_nxt_rx_pid;
  logic       w_timeout;

  logic       w_framing_ok;
  logic [5:0] w_rx_id;
  logic [7:0] w_rx_pid;
  logic       w_parity_ok;
  logic       w_is_uncond;
  logic       w_poll_match;

  assign w_framing_ok = ~data_published[0] & data_published[9];
  assign w_rx_id      = data_published[6:1];
  assign w_rx_pid     = data_published[8:1];
  assign w_parity_ok  = (w_rx_pid == f_pid(w_rx_id));
  assign w_is_uncond  = (w_rx_id == UNCOND_FRAME1) || (w_rx_id == UNCOND_FRAME2);
  // While polling, resolve_pid holds the ID that is being asked for.
  assign w_poll_match = (w_rx_pid == f_pid(r_resolve_pid));

  // Next-state and next-output decode. A response always wins over a
  // timeout in the same cycle.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_collision   = 1'b0;
    w_nxt_frame_ok    = 1'b0;
    w_nxt_rx_error    = 1'b0;
    w_nxt_no_resp     = 1'b0;
    w_nxt_resolve_req = 1'b0;
    w_nxt_resolve_pid = r_resolve_pid;
    w_nxt_rx_pid      = r_rx_pid;
    case (r_state)
      S_IDLE: begin
        if (en_evenTrig_frame) begin
          w_nxt_state = S_WAIT_RESP;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_WAIT_RESP: begin
        if (!en_evenTrig_frame) begin
          w_nxt_state = S_IDLE;
        end else if (rx_valid) begin
          if (!w_framing_ok) begin
            w_nxt_rx_error = 1'b1;
            w_nxt_state    = S_IDLE;
          end else if (w_parity_ok && w_is_uncond) begin
            w_nxt_frame_ok = 1'b1;
            w_nxt_rx_pid   = w_rx_pid;
            w_nxt_state    = S_IDLE;
          end else begin
            w_nxt_collision = 1'b1;
            w_nxt_state     = S_RES1;
          end
        end else if (w_timeout) begin
          w_nxt_no_resp = 1'b1;
          w_nxt_state   = S_IDLE;
        end else begin
          w_nxt_state = S_WAIT_RESP;
        end
      end
      S_RES1: begin
        w_nxt_resolve_req = 1'b1;
        w_nxt_resolve_pid = UNCOND_FRAME1;
        w_nxt_state       = S_WAIT1;
      end
      S_RES2: begin
        w_nxt_resolve_req = 1'b1;
        w_nxt_resolve_pid = UNCOND_FRAME2;
        w_nxt_state       = S_WAIT2;
      end
      S_WAIT1, S_WAIT2: begin
        if (rx_valid || w_timeout) begin
          if (!rx_valid) begin
            w_nxt_no_resp = 1'b1;
          end else if (w_framing_ok && w_poll_match) begin
            w_nxt_frame_ok = 1'b1;
            w_nxt_rx_pid   = w_rx_pid;
          end else begin
            w_nxt_rx_error = 1'b1;
          end
          if (r_state == S_WAIT1) begin
            w_nxt_state = S_RES2;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end else begin
          w_nxt_state = r_state;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset clears the held PIDs as well.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_collision   <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_rx_error    <= 1'b0;
      r_resolve_req <= 1'b0;
      r_resolve_pid <= 6'd0;
      r_rx_pid      <= 8'd0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_collision   <= w_nxt_collision;
      r_frame_ok    <= w_nxt_frame_ok;
      r_rx_error    <= w_nxt_rx_error;
      r_resolve_req <= w_nxt_resolve_req;
      r_resolve_pid <= w_nxt_resolve_pid;
      r_rx_pid      <= w_nxt_rx_pid;
      r_busy        <= (w_nxt_state != S_IDLE);
    end
  end

`ifdef EVT_TRIG_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_no_resp;

  assign w_timeout = (r_cnt == (TIMEOUT_CYC - 16'd1));

  // Wait counter: zero on every state change, counts while a WAIT state persists.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= 16'd0;
    end else if (w_nxt_state != r_state) begin
      r_cnt <= 16'd0;
    end else if ((r_state == S_WAIT_RESP) || (r_state == S_WAIT1) || (r_state == S_WAIT2)) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= 16'd0;
    end
  end

  // Registered no-response pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_no_resp <= 1'b0;
    end else begin
      r_no_resp <= w_nxt_no_resp;
    end
  end

  assign no_resp = r_no_resp;
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign w_unused_cfg = ^{TIMEOUT_CYC, w_nxt_no_resp};
  assign no_resp      = 1'b0;
`endif

  assign collision_detected = r_collision;
  assign frame_ok           = r_frame_ok;
  assign rx_error           = r_rx_error;
  assign resolve_req        = r_resolve_req;
  assign resolve_pid        = r_resolve_pid;
  assign rx_pid             = r_rx_pid;
  assign busy               = r_busy;

endmodule

// File: tb/tb_event_trig_resolver.sv
// Bench for event_trig_resolver: directed scenarios, a behavioural model
// checked every cycle, and literal spot checks at key points.
module tb_event_trig_resolver;

  localparam logic [5:0] UF1  = 6'h25;
  localparam logic [5:0] UF2  = 6'h26;
  localparam int         TOUT = 4;
`ifdef EVT_TRIG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [9:0] F25     = 10'b1_00_100101_0;
  localparam logic [9:0] F24     = 10'b1_00_100100_0;
  localparam logic [9:0] FA6     = 10'b1_10_100110_0;
  localparam logic [9:0] F26BAD  = 10'b1_00_100110_0;
  localparam logic [9:0] F25STRT = 10'b1_00_100101_1;
  localparam logic [9:0] F25STOP = 10'b0_00_100101_0;
  localparam logic [9:0] F25PAR  = 10'b1_01_100101_0;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_evenTrig_frame;
  logic       rx_valid;
  logic [9:0] data_published;
  logic       collision_detected, frame_ok, rx_error, no_resp, resolve_req, busy;
  logic [5:0] resolve_pid;
  logic [7:0] rx_pid;

  int n_cmp = 0;
  int n_bad = 0;

  event_trig_resolver #(
    .UNCOND_FRAME1(UF1),
    .UNCOND_FRAME2(UF2),
    .TIMEOUT_CYC  (16'd4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .en_evenTrig_frame (en_evenTrig_frame),
    .rx_valid          (rx_valid),
    .data_published    (data_published),
    .collision_detected(collision_detected),
    .frame_ok          (frame_ok),
    .rx_error          (rx_error),
    .no_resp           (no_resp),
    .resolve_req       (resolve_req),
    .resolve_pid       (resolve_pid),
    .rx_pid            (rx_pid),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Protected ID from parity rules, computed by counting ones.
  function automatic logic [7:0] pid_of(input logic [5:0] id);
    int ones0;
    int ones1;
    logic p0;
    logic p1;
    ones0 = $countones(id & 6'b010111);
    ones1 = $countones(id & 6'b111010);
    p0 = (ones0 % 2 == 1);
    p1 = (ones1 % 2 == 0);
    return {p1, p0, id};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: listening flag, resolution step 1..4, wait cycle count.
  logic       m_listen = 1'b0;
  int         m_seq = 0;
  int         m_cnt = 0;
  logic       e_coll = 1'b0, e_ok = 1'b0, e_err = 1'b0, e_nr = 1'b0, e_req = 1'b0, e_busy = 1'b0;
  logic [5:0] e_rpid = 6'd0;
  logic [7:0] e_rxpid = 8'd0;

  always @(posedge clk) begin : model
    logic       t_listen, t_coll, t_ok, t_err, t_nr, t_req, fr_good, tmo;
    int         t_seq, t_cnt;
    logic [5:0] t_rpid, id, poll;
    logic [7:0] t_rxpid, pb;
    t_listen = m_listen; t_seq = m_seq; t_cnt = m_cnt + 1;
    t_coll = 1'b0; t_ok = 1'b0; t_err = 1'b0; t_nr = 1'b0; t_req = 1'b0;
    t_rpid = e_rpid; t_rxpid = e_rxpid;
    id = data_published[6:1];
    pb = data_published[8:1];
    fr_good = !data_published[0] && data_published[9];
    tmo = TO_EN && (m_cnt == TOUT - 1);
    poll = (m_seq == 2) ? UF1 : UF2;
    if (!reset) begin
      t_listen = 1'b0; t_seq = 0; t_cnt = 0; t_rpid = 6'd0; t_rxpid = 8'd0;
    end else if (m_listen) begin
      if (!en_evenTrig_frame) begin
        t_listen = 1'b0;
      end else if (rx_valid) begin
        t_listen = 1'b0;
        if (!fr_good) t_err = 1'b1;
        else if (pb == pid_of(id) && (id == UF1 || id == UF2)) begin
          t_ok = 1'b1; t_rxpid = pb;
        end else begin
          t_coll = 1'b1; t_seq = 1;
        end
      end else if (tmo) begin
        t_nr = 1'b1; t_listen = 1'b0;
      end
    end else if (m_seq == 1 || m_seq == 3) begin
      t_req = 1'b1; t_rpid = (m_seq == 1) ? UF1 : UF2; t_seq = m_seq + 1; t_cnt = 0;
    end else if (m_seq == 2 || m_seq == 4) begin
      if (rx_valid || tmo) begin
        if (!rx_valid) t_nr = 1'b1;
        else if (fr_good && pb == pid_of(poll)) begin
          t_ok = 1'b1; t_rxpid = pb;
        end else t_err = 1'b1;
        t_seq = (m_seq == 4) ? 0 : 3;
      end
    end else if (en_evenTrig_frame) begin
      t_listen = 1'b1; t_cnt = 0;
    end
    m_listen <= t_listen; m_seq <= t_seq; m_cnt <= t_cnt;
    e_coll <= t_coll; e_ok <= t_ok; e_err <= t_err; e_nr <= t_nr; e_req <= t_req;
    e_rpid <= t_rpid; e_rxpid <= t_rxpid;
    e_busy <= t_listen || (t_seq != 0);
  end

  // Compare every output against the model on each falling edge.
  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("collision_detected", {7'd0, collision_detected}, {7'd0, e_coll});
      chk("frame_ok",           {7'd0, frame_ok},           {7'd0, e_ok});
      chk("rx_error",           {7'd0, rx_error},           {7'd0, e_err});
      chk("no_resp",            {7'd0, no_resp},            {7'd0, e_nr});
      chk("resolve_req",        {7'd0, resolve_req},        {7'd0, e_req});
      chk("resolve_pid",        {2'd0, resolve_pid},        {2'd0, e_rpid});
      chk("rx_pid",             rx_pid,                     e_rxpid);
      chk("busy",               {7'd0, busy},               {7'd0, e_busy});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] d);
    rx_valid = 1'b1;
    data_published = d;
    tick();
    rx_valid = 1'b0;
    data_published = 10'd0;
  endtask

  initial begin : stim
    reset = 1'b0; en_evenTrig_frame = 1'b0; rx_valid = 1'b0; data_published = 10'd0;
    tick(); tick();
    chk("lit_reset_busy", {7'd0, busy}, 8'd0);
    chk("lit_reset_rx_pid", rx_pid, 8'h00);
    chk("lit_reset_resolve_pid", {2'd0, resolve_pid}, 8'h00);
    chk("lit_model_pid25", pid_of(6'h25), 8'h25);
    chk("lit_model_pid26", pid_of(6'h26), 8'hA6);
    reset = 1'b1; tick();

    // Direct accept of frame 0x25.
    en_evenTrig_frame = 1'b1; tick();
    chk("lit_wait_busy", {7'd0, busy}, 8'd1);
    send(F25);
    chk("lit_direct_ok", {7'd0, frame_ok}, 8'd1);
    chk("lit_direct_rx_pid", rx_pid, 8'h25);
    chk("lit_direct_busy", {7'd0, busy}, 8'd0);
    en_evenTrig_frame = 1'b0; tick();
    chk("lit_ok_one_cycle", {7'd0, frame_ok}, 8'd0);

    // Collision, then both polls answered; enable drops mid-sequence.
    en_evenTrig_frame = 1'b1; tick();
    send(F24); en_evenTrig_frame = 1'b0;
    chk("lit_coll", {7'd0, collision_detected}, 8'd1);
    tick();
    chk("lit_req1", {7'd0, resolve_req}, 8'd1);
    chk("lit_req1_pid", {2'd0, resolve_pid}, 8'h25);
    send(F25);
    chk("lit_poll1_ok", {7'd0, frame_ok}, 8'd1);
    tick();
    chk("lit_req2_pid", {2'd0, resolve_pid}, 8'h26);
    send(FA6);
    chk("lit_poll2_ok", {7'd0, frame_ok}, 8'd1);
    chk("lit_poll2_rx_pid", rx_pid, 8'hA6);
    chk("lit_poll2_busy", {7'd0, busy}, 8'd0);
    tick();

    // Framing errors: bad start bit, bad stop bit.
    en_evenTrig_frame = 1'b1; tick();
    send(F25STRT); en_evenTrig_frame = 1'b0;
    chk("lit_start_err", {7'd0, rx_error}, 8'd1);
    chk("lit_start_nocoll", {7'd0, collision_detected}, 8'd0);
    tick();
    en_evenTrig_frame = 1'b1; tick();
    send(F25STOP); en_evenTrig_frame = 1'b0; tick();

    // Parity mismatch -> collision; wrong reply in WAIT1 -> rx_error.
    en_evenTrig_frame = 1'b1; tick();
    send(F25PAR); en_evenTrig_frame = 1'b0; tick();
    send(F26BAD);
    chk("lit_wait1_err", {7'd0, rx_error}, 8'd1);
    tick(); send(FA6); tick();

    // Direct accept of 0x26, then abort with same-cycle rx_valid.
    en_evenTrig_frame = 1'b1; tick();
    send(FA6); tick();
    rx_valid = 1'b1; data_published = F25; en_evenTrig_frame = 1'b0; tick();
    rx_valid = 1'b0; data_published = 10'd0;
    chk("lit_abort_ok", {7'd0, frame_ok}, 8'd0);
    chk("lit_abort_busy", {7'd0, busy}, 8'd0);
    tick();

    // Reset while in WAIT1.
    en_evenTrig_frame = 1'b1; tick();
    send(F24); en_evenTrig_frame = 1'b0; tick();
    reset = 1'b0; tick();
    chk("lit_rst_busy", {7'd0, busy}, 8'd0);
    chk("lit_rst_rx_pid", rx_pid, 8'h00);
    chk("lit_rst_resolve_pid", {2'd0, resolve_pid}, 8'h00);
    reset = 1'b1; en_evenTrig_frame = 1'b1; tick();
    chk("lit_rst_reentry", {7'd0, busy}, 8'd1);
    en_evenTrig_frame = 1'b0; tick();

`ifdef EVT_TRIG_TIMEOUT_EN
    // Silence in both polls.
    en_evenTrig_frame = 1'b1; tick();
    send(F24); en_evenTrig_frame = 1'b0; tick();
    tick(); tick(); tick();
    chk("lit_to_early", {7'd0, no_resp}, 8'd0);
    tick();
    chk("lit_to_wait1", {7'd0, no_resp}, 8'd1);
    tick();
    chk("lit_to_req2", {2'd0, resolve_pid}, 8'h26);
    repeat (4) tick();
    chk("lit_to_wait2", {7'd0, no_resp}, 8'd1);
    chk("lit_to_idle", {7'd0, busy}, 8'd0);
    tick();
    // Reply in the timeout cycle wins.
    en_evenTrig_frame = 1'b1; tick();
    send(F24); en_evenTrig_frame = 1'b0; tick();
    tick(); tick(); tick();
    send(F25);
    chk("lit_prio_ok", {7'd0, frame_ok}, 8'd1);
    chk("lit_prio_nr", {7'd0, no_resp}, 8'd0);
    tick(); tick(); send(FA6); tick();
    // Silence in WAIT_RESP.
    en_evenTrig_frame = 1'b1; tick();
    repeat (4) tick();
    chk("lit_to_resp", {7'd0, no_resp}, 8'd1);
    en_evenTrig_frame = 1'b0; tick(); tick();
`else
    // Without the timeout the polls wait indefinitely.
    en_evenTrig_frame = 1'b1; tick();
    send(F24); en_evenTrig_frame = 1'b0; tick();
    repeat (30) tick();
    chk("lit_nto_busy", {7'd0, busy}, 8'd1);
    chk("lit_nto_nr", {7'd0, no_resp}, 8'd0);
    send(F25); tick(); send(FA6);
    chk("lit_nto_done", {7'd0, busy}, 8'd0);
    tick();
`endif

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
